fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Fetch stage plus the fetch/decode pipeline register of the pipelined RV32I core.
- Holds the PC and selects the next PC from PC+4 or the branch/jump target resolved in execute.
- Presents the PC to instruction memory and registers instruction, PC and PC+4 into decode.
- Obeys the stall/flush/continue controls produced by the hazard unit and counts stall and flush cycles for performance debug.

Parameters:
- ADDR_WIDTH, 32, PC and instruction-memory address width.
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted on flush.
- CNT_WIDTH, 16, width of the performance counters.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- control_f_i  in  pipeline_control  fetch control from the hazard unit: CONTINUE, STALL or FLUSH.
- control_d_i  in  pipeline_control  decode-register control from the hazard unit.
- pc_src_e_i  in  1  branch taken / jump in execute; select the target.
- pc_target_e_i  in  ADDR_WIDTH  target address from execute.
- imem_addr_o  out  ADDR_WIDTH  instruction memory address; combinational, equals pc_f.
- imem_rdata_i  in  DATA_WIDTH  instruction memory read data; combinational, same cycle.
- instr_d_o  out  DATA_WIDTH  registered instruction to decode.
- pc_d_o  out  ADDR_WIDTH  registered PC of instr_d_o.
- pc_plus4_d_o  out  ADDR_WIDTH  registered PC+4 of instr_d_o.
- valid_d_o  out  1  1 when instr_d_o is a real fetched instruction; 0 for a bubble.
- stall_count_o  out  CNT_WIDTH  cycles with control_f_i == STALL.
- flush_count_o  out  CNT_WIDTH  cycles with control_d_i == FLUSH.

Behaviour:
- Reset (async, immediate):
  - pc_f = RESET_PC.
  - instr_d_o = NOP_INSTR.
  - pc_d_o = 0, pc_plus4_d_o = 0, valid_d_o = 0.
  - Both counters = 0.
- Reset mid-operation discards all in-flight state. The first fetch after reset release is at RESET_PC.
- PC register, evaluated per rising edge:
  - control_f_i == STALL: hold pc_f. pc_src_e_i is ignored; stall has priority.
  - Otherwise, if pc_src_e_i = 1: pc_f <= pc_target_e_i.
  - Otherwise: pc_f <= pc_f + 4.
  - control_f_i == FLUSH is treated as CONTINUE.
  - pc_target_e_i is used unmodified; no alignment check.
- PC+4 arithmetic is modulo 2^ADDR_WIDTH, so 32'hFFFF_FFFC + 4 wraps to 0.
- Decode register, updated per rising edge according to control_d_i:
  - CONTINUE: instr_d_o <= imem_rdata_i, pc_d_o <= pc_f, pc_plus4_d_o <= pc_f + 4, valid_d_o <= 1.
  - STALL: all four outputs hold.
  - FLUSH: instr_d_o <= NOP_INSTR, pc_d_o <= 0, pc_plus4_d_o <= 0, valid_d_o <= 0.
  - FLUSH takes effect even if the register was stalled on the previous cycle.
- Latency: an instruction at address A appears on instr_d_o one edge after pc_f == A with control_d_i == CONTINUE.
- Taken branch: the hazard unit issues control_d = FLUSH in the same cycle as pc_src_e_i. The wrong-path instruction is replaced by the NOP, and the target is fetched the next cycle.
- Load-use stall (control_f = STALL, control_d = STALL):
  - pc_f and the decode register both hold.
  - imem_addr_o stays constant.
  - The same instruction is re-presented after release.
- Counters:
  - stall_count_o increments on each edge where control_f_i == STALL.
  - flush_count_o increments on each edge where control_d_i == FLUSH.
  - Both saturate at 2^CNT_WIDTH-1; no wrap.
  - Both are cleared only by reset.
- Combinations not produced by the hazard unit (e.g. control_f = CONTINUE with control_d = STALL) still follow the rules above, independently per register.

Test Plan:
- Reset release, all CONTINUE, imem returns 32'h00A00093 at address 0 -> imem_addr_o steps 0,4,8; one edge later instr_d_o = 32'h00A00093, pc_d_o = 0, pc_plus4_d_o = 4, valid_d_o = 1.
- At pc_f = 8, assert pc_src_e_i = 1, pc_target_e_i = 32'h40, control_d = FLUSH -> next edge pc_f = 32'h40, instr_d_o = 32'h00000013, valid_d_o = 0, flush_count_o = 1; following edge pc_d_o = 32'h40, valid_d_o = 1.
- control_f = control_d = STALL for 2 cycles at pc_f = 32'h10 -> pc_f and decode outputs unchanged for both cycles, stall_count_o = 2; on CONTINUE, pc_f = 32'h14.
- control_f = STALL with pc_src_e_i = 1, target 32'h80 -> pc_f holds; no redirect.
- pc_f = 32'hFFFF_FFFC, CONTINUE -> pc_f = 0, pc_plus4_d_o = 0 after the decode load.
- Assert rst_i asynchronously between edges while valid_d_o = 1 and counters are non-zero -> outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Fetch stage of the pipelined RV32I core: owns the PC, selects the next PC,
// and holds the fetch/decode pipeline register plus stall/flush debug counters.
package fetch_stage_pkg;
    typedef enum logic [1:0] {
        CONTINUE = 2'd0,
        STALL    = 2'd1,
        FLUSH    = 2'd2
    } pipeline_control;
endpackage

module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned     ADDR_WIDTH = 32,
    parameter int unsigned     DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013,
    parameter int unsigned     CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  pipeline_control       control_f_i,
    input  pipeline_control       control_d_i,
    input  logic                  pc_src_e_i,
    input  logic [ADDR_WIDTH-1:0] pc_target_e_i,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic [DATA_WIDTH-1:0] instr_d_o,
    output logic [ADDR_WIDTH-1:0] pc_d_o,
    output logic [ADDR_WIDTH-1:0] pc_plus4_d_o,
    output logic                  valid_d_o,
    output logic [CNT_WIDTH-1:0]  stall_count_o,
    output logic [CNT_WIDTH-1:0]  flush_count_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [ADDR_WIDTH-1:0] pc_f;
    logic [ADDR_WIDTH-1:0] pc_plus4_f;

    // Wraps modulo 2^ADDR_WIDTH by construction.
    assign pc_plus4_f  = pc_f + ADDR_WIDTH'(4);
    assign imem_addr_o = pc_f;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_f <= RESET_PC;
        end else if (control_f_i != STALL) begin
            pc_f <= pc_src_e_i ? pc_target_e_i : pc_plus4_f;
        end
    end

    // FLUSH wins over a previously stalled register; unused encodings load.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_d_o    <= NOP_INSTR;
            pc_d_o       <= '0;
            pc_plus4_d_o <= '0;
            valid_d_o    <= 1'b0;
        end else if (control_d_i == FLUSH) begin
            instr_d_o    <= NOP_INSTR;
            pc_d_o       <= '0;
            pc_plus4_d_o <= '0;
            valid_d_o    <= 1'b0;
        end else if (control_d_i != STALL) begin
            instr_d_o    <= imem_rdata_i;
            pc_d_o       <= pc_f;
            pc_plus4_d_o <= pc_plus4_f;
            valid_d_o    <= 1'b1;
        end
    end

    // Saturating counters, cleared only by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_count_o <= '0;
            flush_count_o <= '0;
        end else begin
            if (control_f_i == STALL && stall_count_o != CNT_MAX)
                stall_count_o <= stall_count_o + CNT_WIDTH'(1);
            if (control_d_i == FLUSH && flush_count_o != CNT_MAX)
                flush_count_o <= flush_count_o + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: PC sequencing, redirect/flush, stalls,
// wrap-around, counter saturation (narrow second instance) and async reset.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    pipeline_control control_f = CONTINUE;
    pipeline_control control_d = CONTINUE;
    logic            pc_src = 1'b0;
    logic [31:0]     pc_target = 32'h0;
    logic [31:0]     imem_addr, imem_rdata;
    logic [31:0]     instr_d, pc_d, pc_plus4_d;
    logic            valid_d;
    logic [15:0]     stall_count, flush_count;
    logic [31:0]     s_addr, s_instr, s_pc_d, s_pc4_d;
    logic            s_valid;
    logic [2:0]      s_stall_count, s_flush_count;
    logic [31:0]     s_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Instruction memory model: fixed word at 0, address-tagged elsewhere.
    function automatic logic [31:0] imem_model(input logic [31:0] a);
        return (a == 32'h0) ? 32'h00A0_0093 : (a ^ 32'hA500_0000);
    endfunction
    assign imem_rdata = imem_model(imem_addr);
    assign s_rdata    = imem_model(s_addr);

    fetch_stage dut (
        .clk_i(clk), .rst_i(rst), .control_f_i(control_f), .control_d_i(control_d),
        .pc_src_e_i(pc_src), .pc_target_e_i(pc_target), .imem_addr_o(imem_addr),
        .imem_rdata_i(imem_rdata), .instr_d_o(instr_d), .pc_d_o(pc_d),
        .pc_plus4_d_o(pc_plus4_d), .valid_d_o(valid_d),
        .stall_count_o(stall_count), .flush_count_o(flush_count)
    );

    fetch_stage #(.CNT_WIDTH(3)) dut_small (
        .clk_i(clk), .rst_i(rst), .control_f_i(control_f), .control_d_i(control_d),
        .pc_src_e_i(pc_src), .pc_target_e_i(pc_target), .imem_addr_o(s_addr),
        .imem_rdata_i(s_rdata), .instr_d_o(s_instr), .pc_d_o(s_pc_d),
        .pc_plus4_d_o(s_pc4_d), .valid_d_o(s_valid),
        .stall_count_o(s_stall_count), .flush_count_o(s_flush_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctrl(input pipeline_control f, input pipeline_control d,
                            input logic src, input logic [31:0] tgt);
        control_f = f; control_d = d; pc_src = src; pc_target = tgt;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want %h", imem_addr, 32'h0); end
        n_checks++; if (instr_d !== 32'h13) begin n_fail++; $display("FAIL reset_instr: got %h want %h", instr_d, 32'h13); end
        n_checks++; if ({pc_d, pc_plus4_d} !== 64'h0) begin n_fail++; $display("FAIL reset_pc_d: got %h/%h want 0/0", pc_d, pc_plus4_d); end
        n_checks++; if (valid_d !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_d); end
        n_checks++; if ({stall_count, flush_count} !== 32'h0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d want 0/0", stall_count, flush_count); end
    endtask

    task automatic test_sequential();
        rst = 1'b0;
        #1;
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL seq_first_addr: got %h want %h", imem_addr, 32'h0); end
        step();
        n_checks++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL seq_addr4: got %h want %h", imem_addr, 32'h4); end
        n_checks++; if (instr_d !== 32'h00A0_0093) begin n_fail++; $display("FAIL seq_instr0: got %h want %h", instr_d, 32'h00A0_0093); end
        n_checks++; if ({pc_d, pc_plus4_d} !== {32'h0, 32'h4}) begin n_fail++; $display("FAIL seq_pc0: got %h/%h want 0/4", pc_d, pc_plus4_d); end
        n_checks++; if (valid_d !== 1'b1) begin n_fail++; $display("FAIL seq_valid: got %b want 1", valid_d); end
        step();
        n_checks++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL seq_addr8: got %h want %h", imem_addr, 32'h8); end
        n_checks++; if ({instr_d, pc_d} !== {32'hA500_0004, 32'h4}) begin n_fail++; $display("FAIL seq_instr4: got %h@%h want a5000004@4", instr_d, pc_d); end
    endtask

    task automatic test_branch();
        set_ctrl(CONTINUE, FLUSH, 1'b1, 32'h40);
        step();
        n_checks++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL br_target: got %h want %h", imem_addr, 32'h40); end
        n_checks++; if ({instr_d, valid_d} !== {32'h13, 1'b0}) begin n_fail++; $display("FAIL br_bubble: got %h v%b want 00000013 v0", instr_d, valid_d); end
        n_checks++; if (pc_d !== 32'h0) begin n_fail++; $display("FAIL br_pc_d: got %h want 0", pc_d); end
        n_checks++; if (flush_count !== 16'd1) begin n_fail++; $display("FAIL br_flush_cnt: got %0d want 1", flush_count); end
        set_ctrl(CONTINUE, CONTINUE, 1'b0, 32'h0);
        step();
        n_checks++; if ({pc_d, valid_d} !== {32'h40, 1'b1}) begin n_fail++; $display("FAIL br_target_d: got %h v%b want 40 v1", pc_d, valid_d); end
        n_checks++; if ({instr_d, imem_addr} !== {32'hA500_0040, 32'h44}) begin n_fail++; $display("FAIL br_after: got %h/%h want a5000040/44", instr_d, imem_addr); end
    endtask

    task automatic test_stall();
        set_ctrl(CONTINUE, FLUSH, 1'b1, 32'hC);
        step();
        set_ctrl(CONTINUE, CONTINUE, 1'b0, 32'h0);
        step();
        n_checks++; if ({imem_addr, pc_d} !== {32'h10, 32'hC}) begin n_fail++; $display("FAIL st_setup: got %h/%h want 10/c", imem_addr, pc_d); end
        set_ctrl(STALL, STALL, 1'b0, 32'h0);
        for (int i = 1; i <= 2; i++) begin
            step();
            n_checks++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL st_hold_pc%0d: got %h want 10", i, imem_addr); end
            n_checks++; if ({instr_d, pc_d, pc_plus4_d, valid_d} !== {32'hA500_000C, 32'hC, 32'h10, 1'b1}) begin
                n_fail++; $display("FAIL st_hold_d%0d: got %h %h %h %b want a500000c c 10 1", i, instr_d, pc_d, pc_plus4_d, valid_d); end
            n_checks++; if (stall_count !== 16'(i)) begin n_fail++; $display("FAIL st_count%0d: got %0d want %0d", i, stall_count, i); end
        end
        set_ctrl(CONTINUE, CONTINUE, 1'b0, 32'h0);
        step();
        n_checks++; if ({imem_addr, pc_d, instr_d} !== {32'h14, 32'h10, 32'hA500_0010}) begin n_fail++; $display("FAIL st_release: got %h %h %h want 14 10 a5000010", imem_addr, pc_d, instr_d); end
        n_checks++; if (flush_count !== 16'd2) begin n_fail++; $display("FAIL st_flush_cnt: got %0d want 2", flush_count); end
    endtask

    task automatic test_stall_priority();
        set_ctrl(STALL, STALL, 1'b1, 32'h80);
        step();
        n_checks++; if (imem_addr !== 32'h14) begin n_fail++; $display("FAIL prio_hold: got %h want 14", imem_addr); end
        n_checks++; if (stall_count !== 16'd3) begin n_fail++; $display("FAIL prio_count: got %0d want 3", stall_count); end
        set_ctrl(CONTINUE, CONTINUE, 1'b0, 32'h0);
        step();
        n_checks++; if ({imem_addr, pc_d} !== {32'h18, 32'h14}) begin n_fail++; $display("FAIL prio_after: got %h/%h want 18/14", imem_addr, pc_d); end
    endtask

    task automatic test_independent();
        set_ctrl(CONTINUE, STALL, 1'b0, 32'h0);
        step();
        n_checks++; if ({imem_addr, pc_d} !== {32'h1C, 32'h14}) begin n_fail++; $display("FAIL ind_dstall: got %h/%h want 1c/14", imem_addr, pc_d); end
        set_ctrl(FLUSH, FLUSH, 1'b0, 32'h0);
        step();
        n_checks++; if ({imem_addr, pc_d, valid_d} !== {32'h20, 32'h0, 1'b0}) begin n_fail++; $display("FAIL ind_flush_after_stall: got %h %h v%b want 20 0 v0", imem_addr, pc_d, valid_d); end
        set_ctrl(FLUSH, CONTINUE, 1'b0, 32'h0);
        step();
        n_checks++; if ({imem_addr, pc_d, valid_d} !== {32'h24, 32'h20, 1'b1}) begin n_fail++; $display("FAIL ind_fflush: got %h %h v%b want 24 20 v1", imem_addr, pc_d, valid_d); end
        n_checks++; if (flush_count !== 16'd3) begin n_fail++; $display("FAIL ind_flush_cnt: got %0d want 3", flush_count); end
    endtask

    task automatic test_wrap();
        set_ctrl(CONTINUE, FLUSH, 1'b1, 32'hFFFF_FFFC);
        step();
        set_ctrl(CONTINUE, CONTINUE, 1'b0, 32'h0);
        step();
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h want 0", imem_addr); end
        n_checks++; if ({pc_d, pc_plus4_d} !== {32'hFFFF_FFFC, 32'h0}) begin n_fail++; $display("FAIL wrap_d: got %h/%h want fffffffc/0", pc_d, pc_plus4_d); end
    endtask

    task automatic test_saturation();
        set_ctrl(STALL, FLUSH, 1'b0, 32'h0);
        repeat (6) step();
        n_checks++; if ({stall_count, flush_count} !== {16'd9, 16'd10}) begin n_fail++; $display("FAIL sat_wide: got %0d/%0d want 9/10", stall_count, flush_count); end
        n_checks++; if ({s_stall_count, s_flush_count} !== {3'd7, 3'd7}) begin n_fail++; $display("FAIL sat_narrow: got %0d/%0d want 7/7", s_stall_count, s_flush_count); end
    endtask

    task automatic test_async_reset();
        set_ctrl(CONTINUE, CONTINUE, 1'b0, 32'h0);
        step();
        n_checks++; if (valid_d !== 1'b1) begin n_fail++; $display("FAIL ar_pre_valid: got %b want 1", valid_d); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({imem_addr, instr_d} !== {32'h0, 32'h13}) begin n_fail++; $display("FAIL ar_addr_instr: got %h/%h want 0/13", imem_addr, instr_d); end
        n_checks++; if ({pc_d, pc_plus4_d, valid_d} !== 65'h0) begin n_fail++; $display("FAIL ar_decode: got %h %h v%b want 0 0 v0", pc_d, pc_plus4_d, valid_d); end
        n_checks++; if ({stall_count, flush_count} !== 32'h0) begin n_fail++; $display("FAIL ar_counts: got %0d/%0d want 0/0", stall_count, flush_count); end
        @(negedge clk);
        rst = 1'b0;
        step();
        n_checks++; if ({imem_addr, instr_d, pc_d} !== {32'h4, 32'h00A0_0093, 32'h0}) begin n_fail++; $display("FAIL ar_restart: got %h %h %h want 4 00a00093 0", imem_addr, instr_d, pc_d); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_stall_priority();
        test_independent();
        test_wrap();
        test_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
